// File: rtl/dcache_pkg.sv
// Shared types, widths and address-split helpers for the write-back data cache.
package dcache_pkg;

  localparam int WORD_W   = 32;
  localparam int LINE_W   = 128;
  localparam int OFFSET_W = 2;
  localparam int INDEX_W  = 3;
  localparam int TAG_W    = 32 - INDEX_W - OFFSET_W - 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  typedef struct packed {
    logic [TAG_W-1:0]    tag;
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] offset;
    logic [1:0]          byte_sel;
  } addr_fields_t;

  // The byte select is carried along only so the whole address maps onto the struct.
  function automatic addr_fields_t split_addr(input logic [31:0] addr);
    return addr_fields_t'(addr);
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] addr);
    return split_addr(addr).tag;
  endfunction

  function automatic logic [INDEX_W-1:0] addr_index(input logic [31:0] addr);
    return split_addr(addr).index;
  endfunction

  function automatic logic [OFFSET_W-1:0] addr_offset(input logic [31:0] addr);
    return split_addr(addr).offset;
  endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Valid/dirty/tag/data storage for the cache lines, with a combinational
// read port, a word-write port, a line-fill port and a dirty-clear port.
module dcache_line_array
  import dcache_pkg::*;
#(
  parameter int LINES = 8
) (
  input  logic                clk,
  input  logic                srst,
  input  logic [INDEX_W-1:0]  rd_index,
  output logic                rd_valid,
  output logic                rd_dirty,
  output logic [TAG_W-1:0]    rd_tag,
  output logic [LINE_W-1:0]   rd_data,
  input  logic                wr_en,
  input  logic [INDEX_W-1:0]  wr_index,
  input  logic [OFFSET_W-1:0] wr_offset,
  input  logic [WORD_W-1:0]   wr_data,
  input  logic                fill_en,
  input  logic [INDEX_W-1:0]  fill_index,
  input  logic [TAG_W-1:0]    fill_tag,
  input  logic [LINE_W-1:0]   fill_data,
  input  logic                clean_en,
  input  logic [INDEX_W-1:0]  clean_index
);

  logic                valid_reg [LINES];
  logic                dirty_reg [LINES];
  logic [TAG_W-1:0]    tag_reg   [LINES];
  logic [LINE_W-1:0]   data_reg  [LINES];

  assign rd_valid = valid_reg[rd_index];
  assign rd_dirty = dirty_reg[rd_index];
  assign rd_tag   = tag_reg[rd_index];
  assign rd_data  = data_reg[rd_index];

  genvar gi;
  generate
    for (gi = 0; gi < LINES; gi++) begin : g_line
      logic fill_hit;
      logic wr_hit;
      logic clean_hit;

      assign fill_hit  = fill_en  && (fill_index  == INDEX_W'(gi));
      assign wr_hit    = wr_en    && (wr_index    == INDEX_W'(gi));
      assign clean_hit = clean_en && (clean_index == INDEX_W'(gi));

      always_ff @(posedge clk) begin
        if (srst) begin
          valid_reg[gi] <= 1'b0;
          dirty_reg[gi] <= 1'b0;
        end else if (fill_hit) begin
          valid_reg[gi] <= 1'b1;
          dirty_reg[gi] <= 1'b0;
        end else if (wr_hit) begin
          dirty_reg[gi] <= 1'b1;
        end else if (clean_hit) begin
          dirty_reg[gi] <= 1'b0;
        end
      end

      // Tag and data carry no reset; the valid bit qualifies them.
      always_ff @(posedge clk) begin
        if (fill_hit) begin
          tag_reg[gi]  <= fill_tag;
          data_reg[gi] <= fill_data;
        end else if (wr_hit) begin
          data_reg[gi][{wr_offset, 5'b0} +: WORD_W] <= wr_data;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/dcache_wb.sv
// Direct-mapped write-back, write-allocate data cache: miss FSM, hit compare
// and CPU/memory output muxing around the line array.
module dcache_wb
  import dcache_pkg::*;
#(
  parameter int LINES = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          proc_read_i,
  input  logic          proc_write_i,
  input  logic [31:0]   proc_addr_i,
  input  logic [31:0]   proc_wdata_i,
  output logic [31:0]   proc_rdata_o,
  output logic          proc_stall_o,
  output logic          mem_read_o,
  output logic          mem_write_o,
  output logic [27:0]   mem_addr_o,
  output logic [127:0]  mem_wdata_o,
  input  logic [127:0]  mem_rdata_i,
  input  logic          mem_ready_i
);

  state_t              state_reg;
  logic                request;
  logic                hit;
  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  req_index;
  logic [OFFSET_W-1:0] req_offset;
  logic                rd_valid;
  logic                rd_dirty;
  logic [TAG_W-1:0]    rd_tag;
  logic [LINE_W-1:0]   rd_data;
  logic                wr_en;
  logic                fill_en;
  logic                clean_en;

  assign request    = proc_read_i | proc_write_i;
  assign req_tag    = addr_tag(proc_addr_i);
  assign req_index  = addr_index(proc_addr_i);
  assign req_offset = addr_offset(proc_addr_i);

  assign hit = (state_reg == IDLE) && rd_valid && (rd_tag == req_tag);

  // Reset wins over any array update so an abandoned transaction leaves no trace.
  assign wr_en    = !rst_i && hit && proc_write_i;
  assign fill_en  = !rst_i && (state_reg == ALLOCATE)  && mem_ready_i;
  assign clean_en = !rst_i && (state_reg == WRITEBACK) && mem_ready_i;

  dcache_line_array #(
    .LINES (LINES)
  ) u_lines (
    .clk         (clk_i),
    .srst        (rst_i),
    .rd_index    (req_index),
    .rd_valid    (rd_valid),
    .rd_dirty    (rd_dirty),
    .rd_tag      (rd_tag),
    .rd_data     (rd_data),
    .wr_en       (wr_en),
    .wr_index    (req_index),
    .wr_offset   (req_offset),
    .wr_data     (proc_wdata_i),
    .fill_en     (fill_en),
    .fill_index  (req_index),
    .fill_tag    (req_tag),
    .fill_data   (mem_rdata_i),
    .clean_en    (clean_en),
    .clean_index (req_index)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (request && !hit) begin
            state_reg <= (rd_valid && rd_dirty) ? WRITEBACK : ALLOCATE;
          end
        end
        WRITEBACK: if (mem_ready_i) state_reg <= ALLOCATE;
        ALLOCATE:  if (mem_ready_i) state_reg <= IDLE;
        default:   state_reg <= IDLE;
      endcase
    end
  end

  assign proc_stall_o = request && !hit;
  assign proc_rdata_o = hit ? rd_data[{req_offset, 5'b0} +: WORD_W] : 32'd0;

  always_comb begin
    mem_read_o  = (state_reg == ALLOCATE);
    mem_write_o = (state_reg == WRITEBACK);
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state_reg)
      WRITEBACK: begin
        mem_addr_o  = {rd_tag, req_index};
        mem_wdata_o = rd_data;
      end
      ALLOCATE: begin
        mem_addr_o  = {req_tag, req_index};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dcache_wb.sv
// Scoreboard bench for dcache_wb: a reference tag/data model predicts each
// access and a line memory with 4-cycle latency answers the cache.
module tb_dcache_wb;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          proc_read_i = 1'b0;
  logic          proc_write_i = 1'b0;
  logic [31:0]   proc_addr_i = '0;
  logic [31:0]   proc_wdata_i = '0;
  logic [31:0]   proc_rdata_o;
  logic          proc_stall_o;
  logic          mem_read_o;
  logic          mem_write_o;
  logic [27:0]   mem_addr_o;
  logic [127:0]  mem_wdata_o;
  logic [127:0]  mem_rdata_i = '0;
  logic          mem_ready_i = 1'b0;

  dcache_wb #(.LINES(8)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .proc_read_i  (proc_read_i),
    .proc_write_i (proc_write_i),
    .proc_addr_i  (proc_addr_i),
    .proc_wdata_i (proc_wdata_i),
    .proc_rdata_o (proc_rdata_o),
    .proc_stall_o (proc_stall_o),
    .mem_read_o   (mem_read_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_ready_i  (mem_ready_i)
  );

  always #5 clk_i = ~clk_i;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Main memory contents and the CPU-visible truth of every line.
  logic [127:0] mem_store [logic [27:0]];
  logic [127:0] cpu_view  [logic [27:0]];
  logic         ref_valid [8];
  logic         ref_dirty [8];
  logic [24:0]  ref_tag   [8];

  function automatic logic [127:0] mem_line(input logic [27:0] la);
    logic [127:0] line;
    if (mem_store.exists(la)) return mem_store[la];
    for (int i = 0; i < 4; i++) line[i*32 +: 32] = {la, i[1:0], 2'b01} ^ 32'hA5A5_0000;
    if (la == 28'h000_0004) line[31:0] = 32'hDEAD_BEEF;
    return line;
  endfunction

  function automatic logic [127:0] view_line(input logic [27:0] la);
    if (cpu_view.exists(la)) return cpu_view[la];
    return mem_line(la);
  endfunction

  // Memory model: ready on the 4th cycle of each request.
  int mem_cnt = 0;
  always @(negedge clk_i) begin
    if (mem_read_o || mem_write_o) begin
      mem_cnt++;
      mem_ready_i = (mem_cnt == 4);
      if (mem_read_o) mem_rdata_i = mem_line(mem_addr_o);
      if (mem_ready_i) begin
        if (mem_write_o) mem_store[mem_addr_o] = mem_wdata_o;
        mem_cnt = 0;
      end
    end else begin
      mem_cnt = 0;
      mem_ready_i = 1'b0;
    end
  end

  typedef struct {
    logic         miss;
    logic         dirty_miss;
    int           stalls;
    logic [31:0]  rdata;
    logic [27:0]  wb_addr;
    logic [127:0] wb_data;
    logic [27:0]  rf_addr;
  } exp_t;

  exp_t exp_q[$];

  task automatic reset_model();
    for (int i = 0; i < 8; i++) begin
      ref_valid[i] = 1'b0;
      ref_dirty[i] = 1'b0;
      ref_tag[i]   = '0;
    end
    cpu_view.delete();
  endtask

  // Called at posedge+1; returns at posedge+1 after the access completes.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    exp_t got_e;
    logic [2:0]   idx;
    logic [24:0]  tg;
    logic [27:0]  la;
    logic [6:0]   bit_off;
    logic [127:0] line;
    int           stalls;
    logic         seen_wb, seen_rf, both_hi;
    logic [27:0]  wb_addr, rf_addr;
    logic [127:0] wb_data;
    idx = addr[6:4];
    tg  = addr[31:7];
    la  = addr[31:4];
    bit_off = {addr[3:2], 5'b0};
    e.miss       = !(ref_valid[idx] && ref_tag[idx] == tg);
    e.dirty_miss = e.miss && ref_valid[idx] && ref_dirty[idx];
    e.stalls     = !e.miss ? 0 : (e.dirty_miss ? 9 : 5);
    e.wb_addr    = {ref_tag[idx], idx};
    e.wb_data    = view_line({ref_tag[idx], idx});
    e.rf_addr    = la;
    line         = view_line(la);
    e.rdata      = line[bit_off +: 32];
    exp_q.push_back(e);
    ref_valid[idx] = 1'b1;
    ref_tag[idx]   = tg;
    if (e.miss) ref_dirty[idx] = 1'b0;
    if (wr) begin
      ref_dirty[idx] = 1'b1;
      line[bit_off +: 32] = wdata;
      cpu_view[la] = line;
    end

    proc_read_i  = rd;
    proc_write_i = wr;
    proc_addr_i  = addr;
    proc_wdata_i = wdata;
    stalls = 0;
    seen_wb = 1'b0; seen_rf = 1'b0; both_hi = 1'b0;
    wb_addr = '0; rf_addr = '0; wb_data = '0;
    @(negedge clk_i);
    while (proc_stall_o && stalls < 50) begin
      if (mem_write_o && !seen_wb) begin
        seen_wb = 1'b1; wb_addr = mem_addr_o; wb_data = mem_wdata_o;
      end
      if (mem_read_o && !seen_rf) begin
        seen_rf = 1'b1; rf_addr = mem_addr_o;
      end
      if (mem_read_o && mem_write_o) both_hi = 1'b1;
      stalls++;
      @(negedge clk_i);
    end
    got_e = exp_q.pop_front();
    check_val("stall_cycles", 128'(stalls), 128'(got_e.stalls));
    if (rd) check_val("rdata", 128'(proc_rdata_o), 128'(got_e.rdata));
    check_val("rw_exclusive", 128'(both_hi), 128'(0));
    check_val("idle_mem_addr", 128'(mem_addr_o), 128'(0));
    check_val("wb_seen", 128'(seen_wb), 128'(got_e.dirty_miss));
    check_val("rf_seen", 128'(seen_rf), 128'(got_e.miss));
    if (got_e.dirty_miss) begin
      check_val("wb_addr", 128'(wb_addr), 128'(got_e.wb_addr));
      check_val("wb_data", wb_data, got_e.wb_data);
    end
    if (got_e.miss) check_val("rf_addr", 128'(rf_addr), 128'(got_e.rf_addr));
    $display("[TB] %s addr=%h wdata=%h rdata=%h stalls=%0d", wr ? "WR" : "RD",
             addr, wdata, proc_rdata_o, stalls);
    @(posedge clk_i);
    #1;
    proc_read_i  = 1'b0;
    proc_write_i = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    logic        w;
    reset_model();
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check_val("rst_stall", 128'(proc_stall_o), 128'(0));
    check_val("rst_mem_read", 128'(mem_read_o), 128'(0));
    check_val("rst_mem_write", 128'(mem_write_o), 128'(0));
    @(posedge clk_i);
    #1;

    access(1'b1, 1'b0, 32'h0000_0040, 32'h0);           // clean miss, word 0 = DEADBEEF
    access(1'b1, 1'b0, 32'h0000_0044, 32'h0);           // hit word 1
    access(1'b1, 1'b0, 32'h0000_004C, 32'h0);           // hit word 3
    access(1'b0, 1'b1, 32'h0000_0048, 32'h1234_5678);   // write hit
    access(1'b1, 1'b0, 32'h0000_0048, 32'h0);           // read back
    access(1'b1, 1'b0, 32'h0000_00C0, 32'h0);           // dirty miss, write-back of 0x40 line
    access(1'b0, 1'b1, 32'h0000_0100, 32'hCAFE_F00D);   // write miss to clean line
    access(1'b1, 1'b0, 32'h0000_0100, 32'h0);           // merged word present
    access(1'b1, 1'b0, 32'h0000_0180, 32'h0);           // evicts the dirty 0x100 line

    // Reset while in ALLOCATE abandons the refill.
    proc_read_i = 1'b1;
    proc_addr_i = 32'h0000_0200;
    repeat (2) @(negedge clk_i);
    check_val("alloc_mem_read", 128'(mem_read_o), 128'(1));
    rst_i = 1'b1;
    proc_read_i = 1'b0;
    @(negedge clk_i);
    check_val("abort_mem_read", 128'(mem_read_o), 128'(0));
    check_val("abort_mem_write", 128'(mem_write_o), 128'(0));
    rst_i = 1'b0;
    reset_model();
    $display("[TB] RST during ALLOCATE addr=00000200");
    @(posedge clk_i);
    #1;
    access(1'b1, 1'b0, 32'h0000_0200, 32'h0);           // misses again
    access(1'b1, 1'b0, 32'h0000_0180, 32'h0);           // prior contents invalidated

    for (int i = 0; i < 24; i++) begin
      a = {23'd0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'b00};
      w = 1'($urandom_range(0, 1));
      access(!w, w, a, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dcache_wb.md
# dcache_wb

Direct-mapped, write-back, write-allocate data cache placed between the CPU's data-memory port and a slow, line-wide main memory. On the CPU side it is the responder to the word-level load/store interface and answers hits in the same cycle. It asserts a stall on misses. On the memory side it is the initiator of 128-bit line read and write transactions, using a level request/ready handshake. Data words pass through unchanged, because the cache does not depend on byte order.

## Interface
- LINES, 8: number of cache lines (power of two).
- WORDS_PER_LINE, 4: 32-bit words per line. This is fixed to 4 and is not tested at other values.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- proc_read_i  in  1  load request.
- proc_write_i  in  1  store request.
- proc_addr_i  in  32  byte address; bits [1:0] are ignored.
- proc_wdata_i  in  32  store data.
- proc_rdata_o  out  32  load data; valid when proc_read_i=1 and proc_stall_o=0.
- proc_stall_o  out  1  CPU must hold its request stable while this is high.
- mem_read_o  out  1  line refill request.
- mem_write_o  out  1  line write-back request.
- mem_addr_o  out  28  line address (byte address [31:4]).
- mem_wdata_o  out  128  victim line; word 0 is in bits [31:0].
- mem_rdata_i  in  128  refill line; same packing as mem_wdata_o.
- mem_ready_i  in  1  memory completed the current request; sampled only in WRITEBACK or ALLOCATE.

## Operation
- **Address split (LINES=8):**
  - tag = addr[31:7] (25b)
  - index = addr[6:4]
  - offset = addr[3:2]
- **Per-line state:** valid, dirty, tag, and a 128-bit data field.
- **Requests:**
  - Request = proc_read_i | proc_write_i.
  - If both are high, the access is treated as a write (read data is still driven).
- **Hit:** state is IDLE, the indexed line is valid, and its tag matches.
- **State machine:**
  - **IDLE:**
    - No request: remain in IDLE.
    - Hit: no state change, except that a write updates the word at offset and sets dirty on the clock edge.
    - Miss with victim valid and dirty: go to WRITEBACK.
    - Miss otherwise: go to ALLOCATE.
  - **WRITEBACK:**
    - Drives mem_write_o=1, mem_addr_o={victim tag, index}, and mem_wdata_o=victim line.
    - On the edge where mem_ready_i=1: clear dirty and go to ALLOCATE.
  - **ALLOCATE:**
    - Drives mem_read_o=1 and mem_addr_o={req tag, index}.
    - On the edge where mem_ready_i=1: line data=mem_rdata_i, tag=req tag, valid=1, dirty=0; go to IDLE.
  - The pending access is then completed as a hit in IDLE. A write miss merges its word on that cycle and sets dirty.
- **Outputs:**
  - mem_read_o and mem_write_o decode from the registered state only, so they are never both high.
  - proc_stall_o = request & ~(IDLE & hit); this is combinational.
  - proc_rdata_o = indexed word on a hit, otherwise 0.
  - mem_addr_o and mem_wdata_o are 0 in IDLE.
- **Reset:**
  - State goes to IDLE and all valid and dirty bits clear.
  - Tag and data contents are don't-care.
  - If reset arrives in WRITEBACK or ALLOCATE, the transaction is abandoned. mem_read_o and mem_write_o are low from the next cycle, and no line is updated.

## Timing
- Read or write hit: 0 stall cycles; the write is visible to a load on the next cycle.
- Clean miss:
  - The miss cycle, followed by R cycles in ALLOCATE (R ≥ 1, with mem_ready_i high on the R-th), gives a stall of R+1 cycles.
  - proc_stall_o falls in the first IDLE cycle after refill.
- Dirty miss: W cycles in WRITEBACK plus R cycles in ALLOCATE gives a stall of W+R+1 cycles.
- Memory handshake:
  - A request is held until the edge where ready is sampled.
  - The request deasserts in the following cycle, so there is no back-to-back request of the same type on consecutive cycles.
- Request dropped by the CPU mid-miss: illegal (protocol violation); behaviour is not checked.

## Structure
- Package dcache_pkg holds:
  - the state enum (IDLE, WRITEBACK, ALLOCATE);
  - TAG_W, INDEX_W, OFFSET_W, LINE_W=128;
  - helper functions to extract tag, index and offset from an address.
- Sub-module dcache_line_array contains the valid, dirty, tag and data storage, with synchronous reset of valid and dirty. It provides:
  - a combinational read port by index;
  - a write-word port;
  - a fill-line port.
- The top level holds the FSM, hit compare, and output muxing.

## Test plan
- Reset, then read 0x0000_0040 with a memory model where ready follows 4 cycles after a request:
  - mem_read_o=1 with mem_addr_o=0x000_0004 for 4 cycles; stall lasts 5 cycles.
  - The returned line word 0 (0xDEAD_BEEF) appears on proc_rdata_o.
- Read 0x44 then 0x4C immediately after the refill: both hit, with 0 stall cycles and words 1 and 3 of the line.
- Write 0x1234_5678 to 0x48 (hit), then read 0x48: no stall, and the read returns 0x1234_5678.
- Read 0x0000_00C0, which has the same index as 0x40 and a different tag, while that line is dirty:
  - mem_write_o=1, addr 0x000_0004, containing 0x1234_5678 in bits [95:64].
  - mem_read_o follows for addr 0x000_000C.
  - mem_read_o and mem_write_o are never high in the same cycle.
- Write miss to clean line 0x100: refill, then the merged word is present, dirty=1, and a later eviction writes it back.
- Assert rst_i for 1 cycle in ALLOCATE:
  - mem_read_o is low the next cycle.
  - A subsequent read of the same address misses again.
